tick_stopwatch: RTL and testbench

Centisecond BCD stopwatch that consumes the 100 Hz single-cycle `tick` strobe produced by the team's clock divider (1,000,000-cycle period at 100 MHz). It counts elapsed time from 00.00 to 99.99 s and offers start/stop, clear and lap-freeze control. It drives the four-digit seven-segment display path with BCD digits and status flags.

---
 rtl/stopwatch_pkg.sv | 24 ++
 rtl/tick_stopwatch_if.sv | 24 ++
 rtl/bcd_digit.sv | 37 +++
 rtl/tick_stopwatch.sv | 135 +++++++++++++
 tb/tb_tick_stopwatch.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the centisecond BCD stopwatch.
// bcd_step is the single definition of decade-digit advance used across files.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } sw_state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam int         DIGITS  = 4;

  function automatic logic [3:0] bcd_step(input logic [3:0] q, input logic en);
    logic [3:0] r;
    r = q;
    if (en) begin
      r = (q == BCD_MAX) ? 4'd0 : q + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_stopwatch_if.sv
// Control pulses in, display digits and status flags out.
// No handshake: each control pulse is consumed in the cycle it is high; holding one high for N cycles acts as N pulses.
interface tick_stopwatch_if;

  logic        tick;
  logic        start_stop;
  logic        clear;
  logic        lap;
  logic [15:0] disp;
  logic        running;
  logic        frozen;
  logic        wrapped;

  modport master (
    output tick, start_stop, clear, lap,
    input  disp, running, frozen, wrapped
  );

  modport slave (
    input  tick, start_stop, clear, lap,
    output disp, running, frozen, wrapped
  );

endinterface

// File: rtl/bcd_digit.sv
// One cascadable decade counter; carry is combinational so a chain of digits
// advances in a single cycle.
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       clr,
  output logic [3:0] q,
  output logic       carry
);

  logic [3:0] q_q;
  logic [3:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = 4'd0;
    end else begin
      q_d = bcd_step(q_q, en);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q     = q_q;
  assign carry = en && (q_q == BCD_MAX);

endmodule

// File: rtl/tick_stopwatch.sv
// Centisecond BCD stopwatch: four chained decade digits, a run/pause/lap FSM,
// a display register that can be frozen for lap times, and a sticky wrap flag.
module tick_stopwatch
  import stopwatch_pkg::*;
#(
  parameter bit SATURATE = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  tick_stopwatch_if.slave         bus,
  output sw_state_t               dbg_state
);

  sw_state_t   state_q, state_d;
  logic [15:0] disp_q, disp_d;
  logic        running_q, running_d;
  logic        frozen_q, frozen_d;
  logic        wrapped_q, wrapped_d;

  logic        adv;
  logic        sat_hit;
  logic        wrap_hit;
  logic        counting;
  logic        all_nines;
  logic [15:0] count_now;
  logic [15:0] count_nxt;

  // Digit 0 is cs_ones; each later digit is enabled by the previous digit's carry.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic       en_i;
    logic       carry_i;
    logic [3:0] q_i;

    if (i == 0) begin : g_first
      assign en_i = adv;
    end else begin : g_chain
      assign en_i = g_digit[i-1].carry_i;
    end

    bcd_digit u_digit (
      .clk   (clk),
      .reset (reset),
      .en    (en_i),
      .clr   (bus.clear),
      .q     (q_i),
      .carry (carry_i)
    );

    assign count_now[4*i +: 4] = q_i;
    assign count_nxt[4*i +: 4] = bcd_step(q_i, en_i);
  end

  assign wrap_hit  = g_digit[DIGITS-1].carry_i;
  assign all_nines = (count_now == 16'h9999);
  assign counting  = (state_q == RUN) || (state_q == LAP);

  // Next state and count enable; clear beats start_stop beats lap.
  always_comb begin
    state_d = state_q;
    adv     = 1'b0;
    sat_hit = 1'b0;
    if (bus.clear) begin
      state_d = IDLE;
    end else if (bus.start_stop) begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        LAP:     state_d = PAUSE;
        default: state_d = IDLE;
      endcase
    end else begin
      if (bus.lap) begin
        if (state_q == RUN) begin
          state_d = LAP;
        end else if (state_q == LAP) begin
          state_d = RUN;
        end
      end
      if (counting && bus.tick) begin
        if (SATURATE && all_nines) begin
          sat_hit = 1'b1;
          state_d = PAUSE;
        end else begin
          adv = 1'b1;
        end
      end
    end
  end

  // Display tracks the post-edge count unless a lap freeze is active; entering LAP
  // captures the count as it stands before this cycle's tick.
  always_comb begin
    disp_d    = disp_q;
    wrapped_d = wrapped_q;
    if (bus.clear) begin
      disp_d    = 16'h0000;
      wrapped_d = 1'b0;
    end else begin
      if (sat_hit || wrap_hit) begin
        wrapped_d = 1'b1;
      end
      if (state_d != LAP) begin
        disp_d = count_nxt;
      end else if (state_q != LAP) begin
        disp_d = count_now;
      end
    end
    running_d = (state_d == RUN) || (state_d == LAP);
    frozen_d  = (state_d == LAP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      disp_q    <= 16'h0000;
      running_q <= 1'b0;
      frozen_q  <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      disp_q    <= disp_d;
      running_q <= running_d;
      frozen_q  <= frozen_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign bus.disp    = disp_q;
  assign bus.running = running_q;
  assign bus.frozen  = frozen_q;
  assign bus.wrapped = wrapped_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_tick_stopwatch.sv
// Bench for tick_stopwatch: wrap and saturate variants driven side by side and
// compared each cycle against an integer-count reference model.
module tb_tick_stopwatch;
  import stopwatch_pkg::*;

  localparam int EW      = 19;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_LAP   = 3;

  logic clk        = 1'b0;
  logic rst_n      = 1'b0;
  logic tick       = 1'b0;
  logic start_stop = 1'b0;
  logic clear      = 1'b0;
  logic lap        = 1'b0;

  sw_state_t dbg0, dbg1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [EW-1:0] exp_q[$];

  int m_cnt  [2];
  int m_st   [2];
  int m_disp [2];
  bit m_wr   [2];

  tick_stopwatch_if sw0 ();
  tick_stopwatch_if sw1 ();

  assign sw0.tick       = tick;
  assign sw0.start_stop = start_stop;
  assign sw0.clear      = clear;
  assign sw0.lap        = lap;
  assign sw1.tick       = tick;
  assign sw1.start_stop = start_stop;
  assign sw1.clear      = clear;
  assign sw1.lap        = lap;

  tick_stopwatch #(.SATURATE(1'b0)) dut0 (
    .clk       (clk),
    .reset     (rst_n),
    .bus       (sw0.slave),
    .dbg_state (dbg0)
  );

  tick_stopwatch #(.SATURATE(1'b1)) dut1 (
    .clk       (clk),
    .reset     (rst_n),
    .bus       (sw1.slave),
    .dbg_state (dbg1)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i]  = 0;
      m_st[i]   = M_IDLE;
      m_disp[i] = 0;
      m_wr[i]   = 1'b0;
    end
  endtask

  // Reference: elapsed time as a plain integer 0..9999 of centiseconds.
  task automatic model_step(input int i, input bit sat, input bit tk, input bit ss,
                            input bit cl, input bit lp);
    int nst;
    if (cl) begin
      m_cnt[i]  = 0;
      m_st[i]   = M_IDLE;
      m_disp[i] = 0;
      m_wr[i]   = 1'b0;
    end else if (ss) begin
      case (m_st[i])
        M_IDLE:  m_st[i] = M_RUN;
        M_RUN:   m_st[i] = M_PAUSE;
        M_PAUSE: m_st[i] = M_RUN;
        default: m_st[i] = M_PAUSE;
      endcase
      m_disp[i] = m_cnt[i];
    end else begin
      nst = m_st[i];
      if (lp && m_st[i] == M_RUN) begin
        nst       = M_LAP;
        m_disp[i] = m_cnt[i];
      end else if (lp && m_st[i] == M_LAP) begin
        nst = M_RUN;
      end
      if (tk && (m_st[i] == M_RUN || m_st[i] == M_LAP)) begin
        if (m_cnt[i] == 9999) begin
          m_wr[i] = 1'b1;
          if (sat) nst = M_PAUSE;
          else     m_cnt[i] = 0;
        end else begin
          m_cnt[i] = m_cnt[i] + 1;
        end
      end
      m_st[i] = nst;
      if (m_st[i] != M_LAP) m_disp[i] = m_cnt[i];
    end
    exp_q.push_back({m_wr[i], m_st[i] == M_LAP, (m_st[i] == M_RUN) || (m_st[i] == M_LAP),
                     to_bcd(m_disp[i])});
  endtask

  // scoreboard
  task automatic scoreboard();
    logic [EW-1:0] e;
    check_eq("sb_depth", 32'(exp_q.size()), 32'd2);
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      check_eq("dut0_out", 32'({sw0.wrapped, sw0.frozen, sw0.running, sw0.disp}), 32'(e));
      e = exp_q.pop_front();
      check_eq("dut1_out", 32'({sw1.wrapped, sw1.frozen, sw1.running, sw1.disp}), 32'(e));
    end
    exp_q.delete();
  endtask

  // driver
  task automatic cycle(input bit tk, input bit ss, input bit cl, input bit lp);
    tick       = tk;
    start_stop = ss;
    clear      = cl;
    lap        = lp;
    @(posedge clk);
    model_step(0, 1'b0, tk, ss, cl, lp);
    model_step(1, 1'b1, tk, ss, cl, lp);
    #1;
    scoreboard();
    tick       = 1'b0;
    start_stop = 1'b0;
    clear      = 1'b0;
    lap        = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    for (int k = 0; k < n; k++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear_and_start();
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("reset_disp", 32'(sw0.disp), 32'h0);
    check_eq("reset_running", 32'(sw0.running), 32'h0);
    check_eq("reset_frozen", 32'(sw0.frozen), 32'h0);
    check_eq("reset_wrapped", 32'(sw1.wrapped), 32'h0);
    rst_n = 1'b1;

    // start then 123 ticks
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    run_ticks(123);
    check_eq("count_123", 32'(sw0.disp), 32'h0123);
    check_eq("count_123_run", 32'(sw0.running), 32'h1);

    // pause ignores ticks, resume counts again
    clear_and_start();
    run_ticks(50);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    run_ticks(20);
    check_eq("pause_hold", 32'(sw0.disp), 32'h0050);
    check_eq("pause_running", 32'(sw0.running), 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("resume_count", 32'(sw0.disp), 32'h0051);

    // lap freeze and release
    clear_and_start();
    run_ticks(200);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    run_ticks(30);
    check_eq("lap_frozen_disp", 32'(sw0.disp), 32'h0200);
    check_eq("lap_frozen_flag", 32'(sw0.frozen), 32'h1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("lap_release_disp", 32'(sw0.disp), 32'h0230);
    check_eq("lap_release_flag", 32'(sw0.frozen), 32'h0);

    // rollover: wrap variant vs saturate variant
    clear_and_start();
    run_ticks(9999);
    check_eq("preload_9999", 32'(sw0.disp), 32'h9999);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("wrap_disp", 32'(sw0.disp), 32'h0000);
    check_eq("wrap_flag", 32'(sw0.wrapped), 32'h1);
    check_eq("wrap_running", 32'(sw0.running), 32'h1);
    check_eq("sat_disp", 32'(sw1.disp), 32'h9999);
    check_eq("sat_running", 32'(sw1.running), 32'h0);
    check_eq("sat_flag", 32'(sw1.wrapped), 32'h1);

    // clear + start_stop + tick together, with wrapped still set
    run_ticks(42);
    check_eq("pre_clear_disp", 32'(sw0.disp), 32'h0042);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("clr_disp", 32'(sw0.disp), 32'h0);
    check_eq("clr_running", 32'(sw0.running), 32'h0);
    check_eq("clr_wrapped", 32'(sw0.wrapped), 32'h0);
    check_eq("clr_idle", 32'(dbg0 == IDLE), 32'h1);
    check_eq("clr_wrapped_sat", 32'(sw1.wrapped), 32'h0);

    // asynchronous reset mid-run
    clear_and_start();
    run_ticks(777);
    check_eq("pre_reset_disp", 32'(sw0.disp), 32'h0777);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_disp", 32'(sw0.disp), 32'h0);
    check_eq("async_rst_running", 32'(sw0.running), 32'h0);
    check_eq("async_rst_idle", 32'(dbg1 == IDLE), 32'h1);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("rst_tick_no_start", 32'(sw0.disp), 32'h0);
    check_eq("rst_tick_running", 32'(sw0.running), 32'h0);

    // randomized control mix
    for (int k = 0; k < 3000; k++) begin
      cycle(1'($urandom_range(0, 1)),
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 79) == 0,
            $urandom_range(0, 7) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
